// File: rtl/spi_slave.sv
// SPI mode-0 slave with 8-bit MSB-first frames, oversampled on clk.
// Received bytes are strobed out on data/valid and echoed back on miso during the next byte.
module spi_slave (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] data,
  output logic       valid
);

  logic       r_sclk_q;
  logic       r_sclk_qq;
  logic       r_mosi_q;
  logic       r_ss_q;
  logic [2:0] r_bitcnt;
  logic [6:0] r_rx_shift;
  logic [7:0] r_echo;
  logic [7:0] r_data;
  logic       r_valid;

  logic       w_rise;
  logic [7:0] w_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_q  <= 1'b0;
      r_sclk_qq <= 1'b0;
      r_mosi_q  <= 1'b0;
      r_ss_q    <= 1'b0;
    end else begin
      r_sclk_q  <= sclk;
      r_sclk_qq <= r_sclk_q;
      r_mosi_q  <= mosi;
      r_ss_q    <= ss;
    end
  end

  // Gating with r_ss_q makes a release win over a coincident rise.
  assign w_rise = r_sclk_q & ~r_sclk_qq & r_ss_q;
  assign w_byte = {r_rx_shift, r_mosi_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bitcnt   <= 3'd0;
      r_rx_shift <= 7'd0;
      r_echo     <= 8'd0;
      r_data     <= 8'd0;
      r_valid    <= 1'b0;
    end else if (!r_ss_q) begin
      r_bitcnt   <= 3'd0;
      r_rx_shift <= 7'd0;
      r_valid    <= 1'b0;
    end else if (w_rise) begin
      r_rx_shift <= w_byte[6:0];
      r_bitcnt   <= r_bitcnt + 3'd1;
      if (r_bitcnt == 3'd7) begin
        r_data  <= w_byte;
        r_echo  <= w_byte;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  // Bit index only moves after a detected rise, so miso is settled before the next one.
  assign miso  = r_ss_q ? r_echo[3'd7 - r_bitcnt] : 1'b0;
  assign data  = r_data;
  assign valid = r_valid;

endmodule

// File: tb/tb_spi_slave.sv
// Directed and randomized bench for spi_slave; the model tracks expected bytes and the echo byte.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       ss = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] data;
  logic       valid;

  int n_chk  = 0;
  int n_pass = 0;

  int         got_cnt = 0;
  logic [7:0] last_got = 8'h00;
  int         dbl = 0;
  logic       prev_v = 1'b0;

  int         m_cnt = 0;
  logic [7:0] m_echo = 8'h00;

  spi_slave dut (
    .clk   (clk),
    .rst   (rst),
    .sclk  (sclk),
    .ss    (ss),
    .mosi  (mosi),
    .miso  (miso),
    .data  (data),
    .valid (valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      got_cnt++;
      last_got = data;
      if (prev_v === 1'b1) dbl++;
    end
    prev_v = valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sclk period: 2 clk high, 2 clk low; miso is checked just before the rise.
  task automatic send_bit(input logic b, input logic exp_miso, input bit chk);
    @(negedge clk);
    mosi = b;
    if (chk) check("miso", {31'd0, miso}, {31'd0, exp_miso});
    sclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sclk = 1'b0;
    @(negedge clk);
  endtask

  // Full byte with ss held: model echo is what miso must show, then the byte becomes the echo.
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i], m_echo[i], 1'b1);
    m_cnt++;
    m_echo = b;
    check("valid_count", got_cnt, m_cnt);
    check("data", {24'd0, last_got}, {24'd0, b});
  endtask

  initial begin
    logic [7:0] b;

    idle(3);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd0);
    rst = 1'b1;
    idle(2);

    // 1: eight ones, with exact valid latency on the last rise
    ss = 1'b1;
    idle(3);
    for (int i = 7; i >= 1; i--) send_bit(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    mosi = 1'b1;
    check("miso", {31'd0, miso}, 32'd0);
    sclk = 1'b1;
    @(negedge clk);
    check("t1_valid_e1", {31'd0, valid}, 32'd0);
    @(negedge clk);
    check("t1_valid_e2", {31'd0, valid}, 32'd1);
    check("t1_data_e2", {24'd0, data}, 32'hFF);
    sclk = 1'b0;
    @(negedge clk);
    check("t1_valid_e3", {31'd0, valid}, 32'd0);
    m_cnt++;
    m_echo = 8'hFF;

    // 2: release holds data, no valid, miso idles low
    ss = 1'b0;
    idle(10);
    check("t2_valid_count", got_cnt, m_cnt);
    check("t2_data", {24'd0, data}, 32'hFF);
    check("t2_miso", {31'd0, miso}, 32'd0);

    // 3: back-to-back bytes, first echoes the previous frame's last byte
    ss = 1'b1;
    idle(3);
    for (int i = 0; i < 4; i++) send_byte(i[7:0]);

    // 4: 257 bytes with long gaps, ss held high
    for (int k = 0; k < 257; k++) begin
      send_byte(k[7:0]);
      idle(k < 16 ? 512 : 128);
      check("t4_gap_count", got_cnt, m_cnt);
    end

    // 5: partial byte discarded by ss release, then 0xA5
    b = 8'h5C;
    for (int i = 7; i >= 3; i--) send_bit(b[i], m_echo[i], 1'b1);
    ss = 1'b0;
    idle(4);
    check("t5_partial_count", got_cnt, m_cnt);
    check("t5_miso_released", {31'd0, miso}, 32'd0);
    ss = 1'b1;
    idle(3);
    send_byte(8'hA5);
    check("t5_data", {24'd0, data}, 32'hA5);

    // randomized bytes with random gaps
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      send_byte(b);
      idle($urandom_range(0, 20));
    end

    // 6: async reset mid-byte
    b = 8'($urandom);
    for (int i = 7; i >= 5; i--) send_bit(b[i], m_echo[i], 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_data", {24'd0, data}, 32'd0);
    check("t6_valid", {31'd0, valid}, 32'd0);
    check("t6_miso", {31'd0, miso}, 32'd0);
    m_echo = 8'h00;
    idle(2);
    rst = 1'b1;
    idle(3);
    check("t6_count_after_rst", got_cnt, m_cnt);
    b = 8'($urandom);
    send_byte(b);
    check("t6_data_after", {24'd0, data}, {24'd0, b});

    ss = 1'b0;
    idle(5);
    check("valid_width", dbl, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
